// File: rtl/conv3x3_psum_ctrl_if.sv
// conv3x3_psum_ctrl_if
//   Bundles the job configuration, status, tree-input handshake and
//   accumulated-psum output of conv3x3_psum_ctrl.
//   master : job issuer / window source / psum sink (drives cfg_*, in_valid,
//            psum_3x3, out_ready)
//   slave  : the controller (drives busy, done, in_ready, pipe_en,
//            out_valid, out_psum, out_last)
interface conv3x3_psum_ctrl_if #(
    parameter int CH_W  = 8,
    parameter int PIX_W = 16,
    parameter int ACC_W = 32
);
    logic             cfg_start;
    logic [CH_W-1:0]  cfg_ch_num;
    logic [PIX_W-1:0] cfg_pix_num;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic             pipe_en;
    logic [ACC_W-1:0] psum_3x3;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_psum;
    logic             out_last;

    modport master (
        output cfg_start, cfg_ch_num, cfg_pix_num, in_valid, psum_3x3, out_ready,
        input  busy, done, in_ready, pipe_en, out_valid, out_psum, out_last
    );

    modport slave (
        input  cfg_start, cfg_ch_num, cfg_pix_num, in_valid, psum_3x3, out_ready,
        output busy, done, in_ready, pipe_en, out_valid, out_psum, out_last
    );
endinterface

// File: rtl/conv3x3_psum_ctrl.sv
// conv3x3_psum_ctrl
//   Sequences one 3x3 convolution job through a two-register-stage adder
//   tree: accepts pix_num*ch_num product windows, drives the tree enable,
//   tracks valid through both tree stages, accumulates ch_num tree results
//   per pixel and presents one psum per pixel on a valid/ready output.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : conv3x3_psum_ctrl_if.slave (cfg, status, tree in, psum out)
module conv3x3_psum_ctrl #(
    parameter int CH_W  = 8,
    parameter int PIX_W = 16,
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    conv3x3_psum_ctrl_if.slave   bus
);
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CH_W-1:0]  ch_num, in_ch_cnt, acc_cnt;
    logic [PIX_W-1:0] pix_num, in_pix_cnt, out_pix_cnt;
    logic [ACC_W-1:0] acc, sum, out_psum_q;
    logic [STAGES:1]  vld_pipe;   // [1] = v1, [2] = v2 (tree output valid)
    logic             out_valid_q, out_last_q;
    logic             acc_can, in_ready, in_fire, last_beat, acc_en, acc_last;
    logic             cfg_ok, start_run, drain_ok, busy, done;

    // The output register is the only place a stall originates; the tree and
    // every counter freeze with it so nothing in flight is lost.
    assign acc_can   = ~out_valid_q | bus.out_ready;
    assign in_fire   = bus.in_valid & in_ready;
    assign last_beat = in_fire && (in_ch_cnt == ch_num - CH_W'(1))
                               && (in_pix_cnt == pix_num - PIX_W'(1));
    assign acc_en    = vld_pipe[STAGES] & acc_can;
    assign acc_last  = (acc_cnt == ch_num - CH_W'(1));
    assign sum       = (acc_cnt == '0) ? bus.psum_3x3 : acc + bus.psum_3x3;
    assign cfg_ok    = (bus.cfg_ch_num != '0) && (bus.cfg_pix_num != '0);
    assign start_run = (state == IDLE) && bus.cfg_start && cfg_ok;
    assign drain_ok  = ~vld_pipe[1] & ~vld_pipe[2] & (~out_valid_q | bus.out_ready);

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cfg_start) state_nxt = cfg_ok ? RUN : DONE;
            RUN:     if (last_beat)     state_nxt = DRAIN;
            DRAIN:   if (drain_ok)      state_nxt = DONE;
            DONE:                       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        busy     = (state == RUN) || (state == DRAIN);
        done     = (state == DONE);
        in_ready = (state == RUN) && acc_can;
    end

    // ---- datapath ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_num      <= '0;
            pix_num     <= '0;
            in_ch_cnt   <= '0;
            in_pix_cnt  <= '0;
            acc_cnt     <= '0;
            out_pix_cnt <= '0;
            acc         <= '0;
            vld_pipe    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_psum_q  <= '0;
        end else begin
            if (start_run) begin
                ch_num      <= bus.cfg_ch_num;
                pix_num     <= bus.cfg_pix_num;
                in_ch_cnt   <= '0;
                in_pix_cnt  <= '0;
                acc_cnt     <= '0;
                out_pix_cnt <= '0;
            end

            if (in_fire) begin
                if (in_ch_cnt == ch_num - CH_W'(1)) begin
                    in_ch_cnt  <= '0;
                    in_pix_cnt <= in_pix_cnt + PIX_W'(1);
                end else begin
                    in_ch_cnt  <= in_ch_cnt + CH_W'(1);
                end
            end

            if (acc_can) vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};

            // Handshake clears first; a result loading this same cycle wins,
            // keeping back-to-back pixels bubble-free.
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

            if (acc_en) begin
                if (acc_last) begin
                    out_psum_q  <= sum;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (out_pix_cnt == pix_num - PIX_W'(1));
                    acc_cnt     <= '0;
                    out_pix_cnt <= out_pix_cnt + PIX_W'(1);
                end else begin
                    acc         <= sum;
                    acc_cnt     <= acc_cnt + CH_W'(1);
                end
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.in_ready  = in_ready;
    assign bus.pipe_en   = acc_can;
    assign bus.out_valid = out_valid_q;
    assign bus.out_psum  = out_psum_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_conv3x3_psum_ctrl.sv
// tb_conv3x3_psum_ctrl
//   Drives conv3x3_psum_ctrl with directed and randomized jobs. The adder
//   tree is modelled as two enable-gated data registers; expected psums are
//   per-pixel sums of the beat list computed in plain arithmetic.
module tb_conv3x3_psum_ctrl;
    typedef struct packed {
        logic        last;
        logic [31:0] psum;
    } res_t;

    logic clk, rst;
    conv3x3_psum_ctrl_if #(.CH_W(8), .PIX_W(16), .ACC_W(32)) bus ();

    conv3x3_psum_ctrl #(.CH_W(8), .PIX_W(16), .ACC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          n_acc = 0;
    int          done_cnt = 0;
    bit          in_ready_seen = 0;
    res_t        got_q[$];
    logic [31:0] beats[$];
    bit          vpat[$];
    logic [31:0] in_data, t1, t2;

    // External adder tree: two data registers sharing the controller's enable.
    always @(posedge clk) if (bus.pipe_en) begin
        t1 <= in_data;
        t2 <= t1;
    end
    assign bus.psum_3x3 = t2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Monitor at negedge: inputs change just after posedge, so these values
    // are what the next posedge will act on.
    always @(negedge clk) if (!rst) begin
        if (bus.in_valid && bus.in_ready) n_acc++;
        if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.out_psum});
        if (bus.done) done_cnt++;
        if (bus.in_ready) in_ready_seen = 1;
        chk("pipe_en_rule", 64'(bus.pipe_en), 64'(!bus.out_valid || bus.out_ready));
        if (bus.in_ready) chk("in_ready_qual", 64'(bus.busy && bus.pipe_en), 64'd1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // rmode < 0: stall out_ready for 3 cycles once out_valid rises, then 1.
    // poke >= 0: pulse cfg_start with different counts at that loop cycle.
    task automatic run_job(input int ch, input int pix, input int vprob,
                           input int rmode, input int poke);
        res_t        exp_q[$];
        res_t        r;
        logic [31:0] s;
        int          total, d0, stalls;
        bit          finished, v;
        total = ch * pix;
        for (int p = 0; p < pix; p++) begin
            s = 0;
            for (int c = 0; c < ch; c++) s = s + beats[p*ch + c];
            r.psum = s;
            r.last = (p == pix - 1);
            exp_q.push_back(r);
        end
        got_q.delete();
        n_acc  = 0;
        d0     = done_cnt;
        stalls = 0;
        bus.cfg_ch_num  = 8'(ch);
        bus.cfg_pix_num = 16'(pix);
        bus.cfg_start   = 1;
        cyc();
        bus.cfg_start = 0;
        chk("busy_start", 64'(bus.busy), 64'd1);
        finished = 0;
        for (int cy = 0; cy < 3000 && !finished; cy++) begin
            bus.cfg_start = (cy == poke);
            if (cy == poke) begin
                bus.cfg_ch_num  = 8'(ch + 1);
                bus.cfg_pix_num = 16'(pix + 3);
            end
            if (vpat.size() > 0) v = vpat.pop_front();
            else                 v = ($urandom_range(99) < vprob);
            bus.in_valid = v && (n_acc < total);
            in_data      = (n_acc < total) ? beats[n_acc] : 32'd0;
            if (rmode < 0) begin
                if (bus.out_valid && stalls < 3) begin
                    bus.out_ready = 0;
                    stalls++;
                    #1;
                    chk("stall_pipe_en", 64'(bus.pipe_en), 64'd0);
                    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                end else begin
                    bus.out_ready = 1;
                end
            end else begin
                bus.out_ready = ($urandom_range(99) < rmode);
            end
            cyc();
            if (bus.done) finished = 1;
        end
        bus.cfg_start = 0;
        bus.in_valid  = 0;
        bus.out_ready = 0;
        chk("job_done", 64'(finished), 64'd1);
        cyc();
        chk("done_one_cycle", 64'(bus.done), 64'd0);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("result_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("psum", 64'(got_q[i].psum), 64'(exp_q[i].psum));
            chk("last", 64'(got_q[i].last), 64'(exp_q[i].last));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      64'(bus.busy), 64'd0);
        chk({tag, "_done"},      64'(bus.done), 64'd0);
        chk({tag, "_in_ready"},  64'(bus.in_ready), 64'd0);
        chk({tag, "_pipe_en"},   64'(bus.pipe_en), 64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_psum"},  64'(bus.out_psum), 64'd0);
        chk({tag, "_out_last"},  64'(bus.out_last), 64'd0);
    endtask

    initial begin
        int d0;
        rst = 1;
        bus.cfg_start = 0; bus.cfg_ch_num = 0; bus.cfg_pix_num = 0;
        bus.in_valid = 0; bus.out_ready = 0; in_data = 0;
        cyc(); cyc();
        chk_reset_outputs("reset");
        rst = 0;

        // Basic pixel: latency, hold under backpressure, done pulse.
        got_q.delete();
        d0 = done_cnt;
        bus.cfg_ch_num = 1; bus.cfg_pix_num = 1; bus.cfg_start = 1;
        cyc();
        bus.cfg_start = 0;
        chk("basic_busy", 64'(bus.busy), 64'd1);
        chk("basic_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1; in_data = 32'd100;
        cyc();
        bus.in_valid = 0;
        chk("basic_in_ready_after", 64'(bus.in_ready), 64'd0);
        chk("basic_ov_t1", 64'(bus.out_valid), 64'd0);
        cyc();
        chk("basic_ov_t2", 64'(bus.out_valid), 64'd0);
        cyc();
        chk("basic_ov_t3", 64'(bus.out_valid), 64'd1);
        chk("basic_psum", 64'(bus.out_psum), 64'd100);
        chk("basic_last", 64'(bus.out_last), 64'd1);
        cyc();
        chk("basic_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("basic_hold_psum", 64'(bus.out_psum), 64'd100);
        chk("basic_hold_pipe_en", 64'(bus.pipe_en), 64'd0);
        bus.out_ready = 1;
        cyc();
        bus.out_ready = 0;
        chk("basic_done", 64'(bus.done), 64'd1);
        chk("basic_ov_clear", 64'(bus.out_valid), 64'd0);
        cyc();
        chk("basic_done_drop", 64'(bus.done), 64'd0);
        chk("basic_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("basic_results", 64'(got_q.size()), 64'd1);

        // Channel accumulation with signed tree results.
        beats = '{32'd5, 32'hFFFF_FFFE, 32'd7, 32'd1, 32'd1, 32'd1};
        run_job(3, 2, 100, 100, -1);
        chk("chacc_first", 64'(got_q.size() > 0 ? got_q[0].psum : 32'hDEAD), 64'd10);

        // Backpressure: 3-cycle stall on first result, continuous input.
        beats = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_job(1, 4, 100, -1, -1);

        // Bubbles and two's-complement wrap.
        beats = '{32'h7FFF_FFFF, 32'd1};
        vpat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_job(2, 1, 100, 100, -1);
        chk("wrap_value", 64'(got_q.size() > 0 ? got_q[0].psum : 32'hDEAD), 64'h8000_0000);

        // Zero count: straight to DONE, nothing accepted.
        in_ready_seen = 0;
        d0 = done_cnt;
        bus.cfg_ch_num = 0; bus.cfg_pix_num = 5; bus.cfg_start = 1;
        cyc();
        bus.cfg_start = 0;
        chk("zero_done", 64'(bus.done), 64'd1);
        chk("zero_busy", 64'(bus.busy), 64'd0);
        cyc();
        chk("zero_done_drop", 64'(bus.done), 64'd0);
        chk("zero_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("zero_in_ready", 64'(in_ready_seen), 64'd0);

        // cfg_start while RUN must not disturb the job in progress.
        beats = '{32'd11, 32'd22, 32'd33};
        run_job(1, 3, 100, 100, 1);

        // Reset mid-job with both tree stages and the output register full.
        beats.delete();
        for (int i = 0; i < 8; i++) beats.push_back(32'(i + 1));
        bus.cfg_ch_num = 1; bus.cfg_pix_num = 8; bus.cfg_start = 1;
        cyc();
        bus.cfg_start = 0;
        bus.in_valid = 1; in_data = 32'd9;
        for (int i = 0; i < 6; i++) cyc();
        chk("prereset_ov", 64'(bus.out_valid), 64'd1);
        chk("prereset_busy", 64'(bus.busy), 64'd1);
        rst = 1;
        cyc();
        chk_reset_outputs("midreset");
        rst = 0;
        bus.in_valid = 0;
        cyc();
        chk("post_reset_idle", 64'(bus.busy), 64'd0);
        beats = '{32'd40, 32'd2, 32'hFFFF_FFF0, 32'd16};
        run_job(2, 2, 80, 70, -1);

        // Randomized jobs.
        for (int j = 0; j < 5; j++) begin
            int ch, pix;
            ch  = $urandom_range(1, 4);
            pix = $urandom_range(1, 5);
            beats.delete();
            for (int i = 0; i < ch * pix; i++) beats.push_back($urandom);
            run_job(ch, pix, 70, 60, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
